// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit and instruction memory.
interface instr_fetch_unit_if #(
  parameter int ADDR_MAX = 16,
  parameter int DATA_W   = 16
);
  logic                mem_req;
  logic [ADDR_MAX-1:0] mem_addr;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch-control stage around an external PC: reads instruction memory,
// holds the word for decode, strobes the PC once per retired instruction,
// and freezes on a HALT word (all-zero instruction).
module instr_fetch_unit #(
  parameter int ADDR_MAX = 16,
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_MAX-1:0] pc,
  instr_fetch_unit_if.master  mem,
  output logic [DATA_W-1:0]   ir,
  output logic                ir_valid,
  input  logic                ir_ready,
  output logic                pc_enable,
  output logic                pc_jump,
  output logic [DATA_W-1:0]   pc_offset,
  output logic [CNT_W-1:0]    instr_count,
  output logic                halted
);

  typedef enum logic [1:0] {FETCH, HOLD, STEP, HALTED} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] ir_q;

  // The PC only moves at the end of STEP, so pc is already the post-update
  // address whenever FETCH is active and is stable across memory waits.
  assign mem.mem_addr = pc;

  // The HALT word is all zeros, so ir_q already reads 0 in HALTED; the
  // explicit mask keeps the frozen-state output independent of that.
  assign ir = (state == HALTED) ? '0 : ir_q;

  // State register; reset wins in every state and drops any pending request.
  always_ff @(posedge clock) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_n     = state;
    mem.mem_req = 1'b0;
    ir_valid    = 1'b0;
    pc_enable   = 1'b0;
    halted      = 1'b0;
    case (state)
      FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) state_n = (mem.mem_rdata == '0) ? HALTED : HOLD;
      end
      HOLD: begin
        ir_valid = 1'b1;
        if (ir_ready) state_n = STEP;
      end
      STEP: begin
        pc_enable = 1'b1;
        state_n   = FETCH;
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: state_n = FETCH;
    endcase
  end

  // Datapath: capture the fetched word, latch PC control on the decode
  // handshake (held until the next accepted instruction), count retirements.
  always_ff @(posedge clock) begin
    if (reset) begin
      ir_q        <= '0;
      pc_jump     <= 1'b0;
      pc_offset   <= '0;
      instr_count <= '0;
    end else begin
      if (state == FETCH && mem.mem_ack) ir_q <= mem.mem_rdata;
      if (state == HOLD && ir_ready) begin
        pc_jump   <= (ir_q[DATA_W-1 -: 4] == 4'hF);
        pc_offset <= ir_q;
      end
      if (state == STEP) instr_count <= instr_count + 1'b1;
    end
  end

endmodule
